mc_control: RTL and testbench



---
 rtl/mc_pkg.sv | 41 ++++
 rtl/mc_control_alu_decoder.sv | 24 ++
 rtl/mc_control.sv | 145 ++++++++++++++
 tb/tb_mc_control.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared states, ALU codes, opcode/funct values and mux encodings for the multicycle core
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RDEXEC, S_RWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_alu_decoder.sv
// alu_decoder: maps an R-type funct field to its ALU code and flags unsupported functs
module alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       valid
);

    always_comb begin
        alu_op = ALU_ADD;
        valid  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle FSM sequencing fetch/decode/execute/memory/write-back for the shared-ALU datapath
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       ext_zero,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic [3:0] fn_op;
    logic       fn_valid;

    alu_decoder u_dec (
        .funct  (funct),
        .alu_op (fn_op),
        .valid  (fn_valid)
    );

    always_ff @(posedge clk) begin
        state_q <= rst ? S_FETCH : state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        alu_op     = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_zero   = 1'b0;
        pc_src     = PC_ALU;
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_en     = 1'b1;
                alu_src_b = SRCB_FOUR;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                case (opcode)
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_R:                   state_d = fn_valid ? S_RDEXEC : S_FETCH;
                    OP_BEQ:                 state_d = S_BRANCH;
                    OP_J:                   state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
                    default:                state_d = S_FETCH;
                endcase
                illegal = (state_d == S_FETCH);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                retire    = 1'b1;
            end
            S_RDEXEC: begin
                alu_src_a = 1'b1;
                alu_op    = fn_op;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode == OP_ANDI) ? ALU_AND : (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
                ext_zero  = (opcode == OP_ANDI) || (opcode == OP_ORI);
                state_d   = S_IWB;
            end
            S_IWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
                retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // reset abandons the instruction: no strobe may reach the datapath
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed per-instruction checks of the multicycle control FSM outputs
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, retire, illegal;
    logic [6:0] strb;
    int         total = 0;
    int         bad = 0;

    localparam logic [6:0] ST_FETCH = 7'b1101000;
    localparam logic [6:0] ST_NONE  = 7'b0000000;
    localparam logic [6:0] ST_WB    = 7'b0000110;

    mc_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ext_zero   (ext_zero),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // {pc_en, mem_read, mem_write, ir_write, reg_write, retire, illegal}
    assign strb = {pc_en, mem_read, mem_write, ir_write, reg_write, retire, illegal};

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (strb !== ST_NONE) begin bad++; $display("FAIL reset_strobes cyc%0d got=%b exp=%b", i, strb, ST_NONE); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL first_fetch got=%b exp=%b", strb, ST_FETCH); end
        total++;
        if ({alu_src_a, alu_src_b, pc_src} !== 5'b00100) begin bad++; $display("FAIL first_fetch_mux got=%b exp=00100", {alu_src_a, alu_src_b, pc_src}); end
    endtask

    task automatic test_lw();
        logic [6:0] exp [5] = '{ST_FETCH, ST_NONE, ST_NONE, 7'b0100000, ST_WB};
        opcode = 6'h23;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            total++;
            if (strb !== exp[i]) begin bad++; $display("FAIL lw_strobes cyc%0d got=%b exp=%b", i, strb, exp[i]); end
            if (i == 1) begin
                total++;
                if ({alu_src_a, alu_src_b, ext_zero} !== 4'b0110) begin bad++; $display("FAIL lw_decode_mux got=%b exp=0110", {alu_src_a, alu_src_b, ext_zero}); end
            end
            if (i == 2) begin
                total++;
                if ({alu_op, alu_src_a, alu_src_b, ext_zero} !== 8'b0010_1_10_0) begin bad++; $display("FAIL lw_memadr got=%b exp=00101100", {alu_op, alu_src_a, alu_src_b, ext_zero}); end
            end
            if (i == 3) begin
                total++;
                if (i_or_d !== 1'b1) begin bad++; $display("FAIL lw_memrd_iord got=%b exp=1", i_or_d); end
            end
            if (i == 4) begin
                total++;
                if ({reg_dst, mem_to_reg} !== 2'b01) begin bad++; $display("FAIL lw_memwb_mux got=%b exp=01", {reg_dst, mem_to_reg}); end
            end
        end
        @(negedge clk); #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL lw_refetch got=%b exp=%b", strb, ST_FETCH); end
    endtask

    task automatic test_rtype();
        logic [6:0] exp [4] = '{ST_FETCH, ST_NONE, ST_NONE, ST_WB};
        for (int k = 0; k < 2; k++) begin
            logic [3:0] eop;
            opcode = 6'h00;
            funct  = (k == 0) ? 6'h2A : 6'h27;
            eop    = (k == 0) ? 4'd7 : 4'd12;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                total++;
                if (strb !== exp[i]) begin bad++; $display("FAIL r%0d_strobes cyc%0d got=%b exp=%b", k, i, strb, exp[i]); end
                if (i == 2) begin
                    total++;
                    if ({alu_op, alu_src_a, alu_src_b} !== {eop, 3'b100}) begin bad++; $display("FAIL r%0d_exec got=%b exp=%b", k, {alu_op, alu_src_a, alu_src_b}, {eop, 3'b100}); end
                end
                if (i == 3) begin
                    total++;
                    if ({reg_dst, mem_to_reg} !== 2'b10) begin bad++; $display("FAIL r%0d_rwb_mux got=%b exp=10", k, {reg_dst, mem_to_reg}); end
                end
            end
            @(negedge clk); #1;
            total++;
            if (strb !== ST_FETCH) begin bad++; $display("FAIL r%0d_refetch got=%b exp=%b", k, strb, ST_FETCH); end
        end
    endtask

    task automatic test_beq();
        for (int k = 0; k < 2; k++) begin
            logic [6:0] exp [3];
            opcode = 6'h04;
            funct  = 6'h00;
            zero   = (k == 0);
            exp    = '{ST_FETCH, ST_NONE, {zero, 6'b000010}};
            for (int i = 0; i < 3; i++) begin
                if (i > 0) begin @(negedge clk); #1; end
                total++;
                if (strb !== exp[i]) begin bad++; $display("FAIL beq%0d_strobes cyc%0d got=%b exp=%b", k, i, strb, exp[i]); end
                if (i == 2) begin
                    total++;
                    if ({alu_op, pc_src, alu_src_a, alu_src_b} !== 9'b0110_01_1_00) begin bad++; $display("FAIL beq%0d_branch got=%b exp=011001100", k, {alu_op, pc_src, alu_src_a, alu_src_b}); end
                end
            end
            @(negedge clk); #1;
            zero = 1'b0;
            total++;
            if (strb !== ST_FETCH) begin bad++; $display("FAIL beq%0d_refetch got=%b exp=%b", k, strb, ST_FETCH); end
        end
    endtask

    task automatic test_ori();
        logic [6:0] exp [4] = '{ST_FETCH, ST_NONE, ST_NONE, ST_WB};
        opcode = 6'h0D;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            total++;
            if (strb !== exp[i]) begin bad++; $display("FAIL ori_strobes cyc%0d got=%b exp=%b", i, strb, exp[i]); end
            if (i == 2) begin
                total++;
                if ({alu_op, ext_zero, alu_src_a, alu_src_b} !== 8'b0001_1_1_10) begin bad++; $display("FAIL ori_iexec got=%b exp=00011110", {alu_op, ext_zero, alu_src_a, alu_src_b}); end
            end
            if (i == 3) begin
                total++;
                if ({reg_dst, mem_to_reg} !== 2'b00) begin bad++; $display("FAIL ori_iwb_mux got=%b exp=00", {reg_dst, mem_to_reg}); end
            end
        end
        @(negedge clk); #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL ori_refetch got=%b exp=%b", strb, ST_FETCH); end
    endtask

    task automatic test_jump();
        logic [6:0] exp [3] = '{ST_FETCH, ST_NONE, 7'b1000010};
        opcode = 6'h02;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            total++;
            if (strb !== exp[i]) begin bad++; $display("FAIL j_strobes cyc%0d got=%b exp=%b", i, strb, exp[i]); end
            if (i == 2) begin
                total++;
                if (pc_src !== 2'b10) begin bad++; $display("FAIL j_pc_src got=%b exp=10", pc_src); end
            end
        end
        @(negedge clk); #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL j_refetch got=%b exp=%b", strb, ST_FETCH); end
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? 6'h3F : 6'h00;
            funct  = (k == 0) ? 6'h20 : 6'h3F;
            total++;
            if (strb !== ST_FETCH) begin bad++; $display("FAIL ill%0d_fetch got=%b exp=%b", k, strb, ST_FETCH); end
            @(negedge clk); #1;
            total++;
            if (strb !== 7'b0000001) begin bad++; $display("FAIL ill%0d_decode got=%b exp=0000001", k, strb); end
            @(negedge clk); #1;
            total++;
            if (strb !== ST_FETCH) begin bad++; $display("FAIL ill%0d_refetch got=%b exp=%b", k, strb, ST_FETCH); end
        end
    endtask

    task automatic test_reset_mid();
        opcode = 6'h2B;
        for (int i = 1; i < 4; i++) begin @(negedge clk); #1; end
        total++;
        if ({strb, i_or_d} !== 8'b0010010_1) begin bad++; $display("FAIL sw_memwr got=%b exp=00100101", {strb, i_or_d}); end
        rst = 1'b1;
        #1;
        total++;
        if (strb !== ST_NONE) begin bad++; $display("FAIL sw_rst_forced got=%b exp=%b", strb, ST_NONE); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL sw_rst_refetch got=%b exp=%b", strb, ST_FETCH); end
        // lw cut off in MEMADR must not continue into MEMRD
        opcode = 6'h23;
        for (int i = 1; i < 3; i++) begin @(negedge clk); #1; end
        rst = 1'b1;
        #1;
        total++;
        if (strb !== ST_NONE) begin bad++; $display("FAIL lw_rst_forced got=%b exp=%b", strb, ST_NONE); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (strb !== ST_FETCH) begin bad++; $display("FAIL lw_rst_abandon got=%b exp=%b", strb, ST_FETCH); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_ori();
        test_jump();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
